// File: rtl/coeff_bit_packer.sv
// coeff_bit_packer: packs variable-width coefficients (d bits each) into
// W-bit words, LSB-first. The stream bit order matches ByteEncode, so the
// next stage only has to split each word into bytes.
module coeff_bit_packer #(
  parameter int N_BYTES = 4,
  parameter int D_MAX   = 12
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [3:0]         d_i,
  input  logic               coeff_valid_i,
  output logic               coeff_ready_o,
  input  logic [D_MAX-1:0]   coeff_i,
  input  logic               last_i,
  output logic               word_valid_o,
  input  logic               word_ready_i,
  output logic [N_BYTES*8-1:0] word_o,
  output logic               word_last_o,
  output logic               err_o
);
  localparam int W  = N_BYTES * 8;
  localparam int AW = W + D_MAX;           // one full word plus one spill-over coefficient
  localparam int FW = $clog2(AW + 1);
  localparam int DW = $clog2(D_MAX + 1);
  localparam logic [FW-1:0] W_F = FW'(W);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [FW-1:0] fill;
  logic [DW-1:0] d_q;
  logic          err_q;

  logic          d_bad;
  logic [DW-1:0] d_new;
  logic [DW-1:0] d_use;
  logic [AW-1:0] coeff_masked;
  logic [W-1:0]  word_mask;
  logic          coeff_fire;
  logic          word_fire;

  // Width is sampled only on the opening coefficient; illegal widths fall back to D_MAX.
  assign d_bad = (d_i == 4'd0) || (32'(d_i) > D_MAX);
  assign d_new = d_bad ? DW'(D_MAX) : DW'(d_i);
  assign d_use = (state == IDLE) ? d_new : d_q;

  assign coeff_masked = AW'(coeff_i) & ((AW'(1) << d_use) - AW'(1));

  // Never accept while a full word is pending, so acc cannot overflow.
  assign coeff_ready_o = (state != FLUSH) && (fill < W_F);
  assign word_valid_o  = (fill >= W_F) || ((state == FLUSH) && (fill != '0));
  assign word_last_o   = (state == FLUSH) && (fill <= W_F);
  assign word_mask     = (fill >= W_F) ? '1 : ((W'(1) << fill) - W'(1));
  assign word_o        = acc[W-1:0] & word_mask;
  assign err_o         = err_q;

  assign coeff_fire = coeff_valid_i && coeff_ready_o;
  assign word_fire  = word_valid_o && word_ready_i;

  // Frame FSM plus accumulator: append coefficients at fill, drain W bits per word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      acc   <= '0;
      fill  <= '0;
      d_q   <= '0;
      err_q <= 1'b0;
    end else if (coeff_fire) begin
      acc   <= acc | (coeff_masked << fill);
      fill  <= fill + FW'(d_use);
      state <= last_i ? FLUSH : RUN;
      if (state == IDLE) begin
        d_q <= d_new;
        if (d_bad) err_q <= 1'b1;
      end
    end else if (word_fire) begin
      if (word_last_o) begin
        state <= IDLE;
        acc   <= '0;
        fill  <= '0;
        d_q   <= '0;
      end else begin
        acc  <= acc >> W;
        fill <= (fill > W_F) ? (fill - W_F) : '0;
      end
    end
  end
endmodule

// File: tb/tb_coeff_bit_packer.sv
// Bench for coeff_bit_packer: bit-queue reference model checked every cycle,
// directed frames with literal word expectations, then randomized frames.
module tb_coeff_bit_packer;
  localparam int W     = 32;
  localparam int D_MAX = 12;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [3:0]       d_i = '0;
  logic             coeff_valid_i = 1'b0;
  logic             coeff_ready_o;
  logic [D_MAX-1:0] coeff_i = '0;
  logic             last_i = 1'b0;
  logic             word_valid_o;
  logic             word_ready_i = 1'b1;
  logic [W-1:0]     word_o;
  logic             word_last_o;
  logic             err_o;

  coeff_bit_packer #(.N_BYTES(4), .D_MAX(D_MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(d_i),
    .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o),
    .coeff_i(coeff_i), .last_i(last_i),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_o(word_o), .word_last_o(word_last_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stream bits as a queue, plus frame flags.
  bit           mbits[$];
  bit           m_open = 0, m_flush = 0, m_err = 0;
  int           m_d = 0;
  logic [W-1:0] wlog_w[$];
  bit           wlog_l[$];

  // Compare DUT to model, then advance model by whatever transfers the next edge performs.
  always @(negedge clk_i) begin
    bit ev, er, el;
    logic [W-1:0] ew;
    int nb;
    if (!rst_ni) begin
      mbits.delete(); m_open = 0; m_flush = 0; m_err = 0;
      chk("rst_valid", word_valid_o, 0);
      chk("rst_last", word_last_o, 0);
      chk("rst_err", err_o, 0);
    end else begin
      nb = mbits.size();
      ev = (nb >= W) || (m_flush && nb > 0);
      er = !m_flush && (nb < W);
      el = m_flush && (nb <= W);
      ew = '0;
      for (int i = 0; i < W && i < nb; i++) ew[i] = mbits[i];
      chk("coeff_ready", coeff_ready_o, er);
      chk("word_valid", word_valid_o, ev);
      chk("word", word_o, ew);
      chk("err", err_o, m_err);
      if (ev) chk("word_last", word_last_o, el);
      if (ev && word_ready_i) begin
        wlog_w.push_back(ew); wlog_l.push_back(el);
        for (int i = 0; i < W && i < nb; i++) void'(mbits.pop_front());
        if (el) begin m_open = 0; m_flush = 0; end
      end else if (er && coeff_valid_i) begin
        if (!m_open) begin
          m_open = 1;
          if (d_i == 0 || d_i > D_MAX) begin m_d = D_MAX; m_err = 1; end
          else m_d = d_i;
        end
        for (int j = 0; j < m_d; j++) mbits.push_back(coeff_i[j]);
        if (last_i) m_flush = 1;
      end
    end
  end

  // word_ready_i pattern: 0 = always ready, 1 = random, 2 = held low.
  int rdy_mode = 0;
  bit bubbles = 0;
  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       word_ready_i = 1'b1;
      1:       word_ready_i = ($urandom_range(0, 3) != 0);
      default: word_ready_i = 1'b0;
    endcase
  end

  task automatic send(input logic [3:0] d, input logic [D_MAX-1:0] c, input bit last);
    int n = 0;
    bit ok = 0;
    if (bubbles) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    coeff_valid_i = 1'b1; d_i = d; coeff_i = c; last_i = last;
    while (!ok && n < 300) begin
      @(negedge clk_i); ok = coeff_ready_o;
      @(posedge clk_i); #1; n++;
    end
    coeff_valid_i = 1'b0; last_i = 1'b0;
    d_i = 4'($urandom); coeff_i = D_MAX'($urandom);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: got ready=0 for %0d cycles expected ready", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((m_open || mbits.size() != 0) && n < 500) begin @(posedge clk_i); #1; n++; end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got frame still open expected drained");
    end
  endtask

  task automatic expect_word(input int idx, input logic [W-1:0] w, input bit l);
    if (idx >= wlog_w.size()) begin
      checks++; failures++;
      $display("FAIL word_log: got %0d words expected word %0d", wlog_w.size(), idx);
    end else begin
      chk($sformatf("lit_word%0d", idx), wlog_w[idx], w);
      chk($sformatf("lit_last%0d", idx), wlog_l[idx], l);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1; rst_ni = 1'b0;
    @(negedge clk_i);
    chk("reset_valid", word_valid_o, 0);
    chk("reset_ready", coeff_ready_o, 1);
    chk("reset_word", word_o, 0);
    chk("reset_err", err_o, 0);
    repeat (2) @(posedge clk_i);
    #1; rst_ni = 1'b1;
  endtask

  task automatic clear_log();
    wlog_w.delete(); wlog_l.delete();
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D_MAX-1:0] cq[$];
    int len;
    logic [3:0] fd;
    repeat (2) @(posedge clk_i);
    do_reset();

    // d=12 spill into a second word
    clear_log();
    send(4'd12, 12'hABC, 0); send(4'd12, 12'h123, 0); send(4'd12, 12'h456, 1);
    drain();
    chk("t1_nwords", wlog_w.size(), 2);
    expect_word(0, 32'h56123ABC, 0); expect_word(1, 32'h00000004, 1);

    // d=1 exactly one word
    clear_log();
    for (int i = 0; i < 32; i++) send(4'd1, 12'(((i % 2) == 0) ? 1 : 0), i == 31);
    drain();
    chk("t2_nwords", wlog_w.size(), 1);
    expect_word(0, 32'h55555555, 1);

    // d=4 with downstream stalled
    clear_log();
    rdy_mode = 2;
    repeat (3) begin @(posedge clk_i); #1; end
    for (int i = 1; i <= 8; i++) send(4'd4, 12'(i), i == 8);
    repeat (3) begin
      @(negedge clk_i);
      chk("t3_valid", word_valid_o, 1);
      chk("t3_word", word_o, 32'h87654321);
      chk("t3_last", word_last_o, 1);
      chk("t3_ready", coeff_ready_o, 0);
    end
    @(posedge clk_i); #1;
    rdy_mode = 0;
    drain();
    chk("t3_nwords", wlog_w.size(), 1);
    expect_word(0, 32'h87654321, 1);

    // d=10 full word then remainder
    clear_log();
    for (int i = 0; i < 4; i++) send(4'd10, 12'h3FF, i == 3);
    drain();
    chk("t4_nwords", wlog_w.size(), 2);
    expect_word(0, 32'hFFFFFFFF, 0); expect_word(1, 32'h000000FF, 1);

    // d=8 reset mid-frame, then a clean frame
    clear_log();
    send(4'd8, 12'hAA, 0); send(4'd8, 12'hBB, 0);
    do_reset();
    @(negedge clk_i);
    chk("t5_valid_after_rst", word_valid_o, 0);
    @(posedge clk_i); #1;
    send(4'd8, 12'h11, 0); send(4'd8, 12'h22, 0); send(4'd8, 12'h33, 0); send(4'd8, 12'h44, 1);
    drain();
    chk("t5_nwords", wlog_w.size(), 1);
    expect_word(0, 32'h44332211, 1);

    // d=0 is illegal: treated as D_MAX and flagged
    clear_log();
    send(4'd0, 12'hFFF, 1);
    drain();
    chk("t6_err", err_o, 1);
    chk("t6_nwords", wlog_w.size(), 1);
    expect_word(0, 32'h00000FFF, 1);
    do_reset();

    // randomized frames, random backpressure and bubbles
    rdy_mode = 1; bubbles = 1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) fd = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(13, 15));
      else fd = 4'($urandom_range(1, 12));
      len = $urandom_range(1, 20);
      cq.delete();
      for (int i = 0; i < len; i++) cq.push_back(D_MAX'($urandom));
      if ((f % 13) == 7 && len > 2) begin
        for (int i = 0; i < len / 2; i++) send((i == 0) ? fd : 4'($urandom), cq[i], 0);
        do_reset();
      end else begin
        for (int i = 0; i < len; i++) send((i == 0) ? fd : 4'($urandom), cq[i], i == len - 1);
        drain();
      end
    end
    rdy_mode = 0;
    repeat (4) begin @(posedge clk_i); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coeff_bit_packer.md
COEFF_BIT_PACKER -- requirements
Module: coeff_bit_packer

Interface
REQ-001 The block SHALL have parameter N_BYTES, default 4, giving the output word width in bytes (W = N_BYTES*8).
REQ-002 The block SHALL have parameter D_MAX, default 12, giving the maximum coefficient bit width.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
REQ-004 The block SHALL have port clk_i, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port d_i, input, 4 bits: coefficient bit width for the frame.
REQ-007 The block SHALL have port coeff_valid_i, input, 1 bit: a coefficient is offered.
REQ-008 The block SHALL have port coeff_ready_o, output, 1 bit: the packer accepts the offered coefficient.
REQ-009 The block SHALL have port coeff_i, input, D_MAX bits: the coefficient value.
REQ-010 The block SHALL have port last_i, input, 1 bit: this coefficient ends the frame.
REQ-011 The block SHALL have port word_valid_o, output, 1 bit: word_o is valid.
REQ-012 The block SHALL have port word_ready_i, input, 1 bit: downstream, the bits2bytes stage, accepts the word.
REQ-013 The block SHALL have port word_o, output, W bits: packed bits, LSB-first.
REQ-014 The block SHALL have port word_last_o, output, 1 bit: the final word of the frame.
REQ-015 The block SHALL have port err_o, output, 1 bit: sticky flag for an illegal d_i.

Function
REQ-016 A coefficient transfer SHALL occur on a rising edge where coeff_valid_i and coeff_ready_o are both 1.
REQ-017 A word transfer SHALL occur on a rising edge where word_valid_o and word_ready_i are both 1.
REQ-018 Bit j of the k-th coefficient of a frame SHALL occupy stream bit k*d+j, following FIPS 203 ByteEncode order.
REQ-019 Stream bit n SHALL appear at word_o[n mod W] of word floor(n/W).
REQ-020 The block SHALL have three states:
- IDLE (no frame open);
- RUN (frame open);
- FLUSH (last coefficient accepted, draining).
REQ-021 The block SHALL sample d_i only on the first coefficient transfer of a frame (the IDLE transfer) and hold it until the frame ends.
REQ-022 A d_i value of 0 or greater than D_MAX SHALL be latched as D_MAX and SHALL set err_o, which stays at 1 until reset.
REQ-023 The block SHALL ignore coeff_i bits at positions d and above.
REQ-024 The block SHALL use an accumulator acc of W+D_MAX bits and a fill counter fill (number of valid bits in acc).
REQ-025 coeff_ready_o SHALL equal (state is IDLE or RUN) AND fill < W.
REQ-026 A coefficient transfer SHALL OR the masked coefficient into acc at offset fill and SHALL set fill to fill+d.
REQ-027 word_valid_o SHALL be 1 when fill >= W, or when state is FLUSH and fill > 0.
REQ-028 word_o SHALL equal acc[W-1:0], with bits at positions fill and above forced to 0.
REQ-029 word_last_o SHALL be 1 when state is FLUSH and fill <= W.
REQ-030 A word transfer SHALL shift acc right by W, zero-filling, and SHALL set fill to max(fill-W, 0).
REQ-031 Transitions SHALL be as follows:
- IDLE to RUN on a coefficient transfer with last_i=0;
- IDLE or RUN to FLUSH on a coefficient transfer with last_i=1;
- FLUSH to IDLE on the word transfer with word_last_o=1, which also clears acc and fill.
REQ-032 Because coeff_ready_o is 0 whenever fill >= W, a coefficient transfer and a full-word transfer SHALL never coincide.
REQ-033 word_valid_o SHALL assert the cycle after the coefficient transfer that makes fill >= W, or that has last_i=1.
REQ-034 With word_ready_i held at 1, the block SHALL sustain one coefficient per cycle, stalling only for the cycles in which fill >= W.
REQ-035 While word_valid_o=1 and word_ready_i=0, word_o and word_last_o SHALL hold stable.
REQ-036 After the last coefficient, fill SHALL always be >= 1, so every frame emits at least one word with word_last_o=1.
REQ-037 If fill > W in FLUSH, the block SHALL first emit a full word with word_last_o=0, then the remainder with word_last_o=1.

Reset
REQ-038 While rst_ni=0 the block SHALL asynchronously clear:
- state to IDLE;
- acc, fill and the latched d;
- word_valid_o, word_last_o and err_o to 0.
REQ-039 After reset, coeff_ready_o SHALL be 1 and word_o SHALL be 0.
REQ-040 A reset during a frame SHALL discard all partial bits; the next frame SHALL start clean.

Verification
REQ-041 d=12, coefficients 0xABC, 0x123, 0x456 (last) -> word 0x56123ABC with last=0, then 0x00000004 with last=1.
REQ-042 d=1, 32 coefficients alternating 1,0 starting with 1, the 32nd marked last -> single word 0x55555555 with last=1.
REQ-043 d=4, coefficients 1..8 (8 marked last), word_ready_i held 0 for 3 cycles -> 0x87654321 with last=1 held stable and coeff_ready_o=0 throughout.
REQ-044 d=10, four coefficients 0x3FF (last on the 4th) -> 0xFFFFFFFF with last=0, then 0x000000FF with last=1.
REQ-045 d=8, two coefficients then rst_ni pulsed low -> word_valid_o=0; new frame 0x11, 0x22, 0x33, 0x44 (last) -> 0x44332211 with last=1.
REQ-046 d=0, coefficient 0xFFF (last) -> err_o=1, word 0x00000FFF with last=1.
